// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bundle for seq_divider.
// The master side (requester) drives start and operands; the slave side (the
// divider) returns busy, done, quotient, remainder and div_by_zero.
// WIDTH must match the WIDTH of the seq_divider instance it is connected to.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// A start accepted in IDLE or DONE captures the operands; WIDTH iterations later
// the FSM enters DONE for one cycle, pulses done and loads quotient/remainder,
// which then hold until the next DONE load or reset.
// Optional build macro DIV_ZERO_CHECK_EN: a zero divisor bypasses RUN, finishes
// in one cycle and raises div_by_zero. Without it, div_by_zero is tied low and a
// zero divisor simply runs the full algorithm (quotient all ones, remainder =
// dividend).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;        // iterations still to run
  logic [WIDTH-1:0] r_q;          // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_d;          // captured divisor
  // The partial remainder is always below the divisor after restoring, so its
  // top bit is zero between iterations; only the shifted trial value needs the
  // extra bit, and that lives in w_shift_r.
  logic [WIDTH-1:0] r_r;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH:0]   w_shift_r;    // {R,Q} shifted left: R half with Q msb in its lsb
  logic [WIDTH:0]   w_trial;      // T = shifted R - {0,D}
  logic             w_neg;        // trial went negative -> restore
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // Trial subtraction on the shifted partial remainder.
  assign w_shift_r = {r_r, r_q[WIDTH-1]};
  assign w_trial   = w_shift_r - {1'b0, r_d};
  assign w_neg     = w_trial[WIDTH];
  assign w_q_next  = {r_q[WIDTH-2:0], ~w_neg};

  // Restoring mux, one cell per remainder bit: keep the shifted value when the
  // trial went negative, otherwise take the difference.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_restore
      assign w_r_next[gi] = w_neg ? w_shift_r[gi] : w_trial[gi];
    end
  endgenerate

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;

`ifdef DIV_ZERO_CHECK_EN
  logic r_dbz;
  logic w_zero_div;

  assign w_zero_div      = (bus.divisor == '0);
  assign bus.div_by_zero = r_dbz;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
      r_dbz       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // IDLE and DONE accept a new request identically, which gives
        // back-to-back operation with no bubble after done.
        S_IDLE, S_DONE: begin
          r_busy <= 1'b0;
          if (bus.start) begin
            r_q   <= bus.dividend;
            r_d   <= bus.divisor;
            r_r   <= '0;
            r_cnt <= CNT_INIT;
`ifdef DIV_ZERO_CHECK_EN
            if (w_zero_div) begin
              // Result is known up front; skip the iterations entirely.
              r_state     <= S_DONE;
              r_cnt       <= '0;
              r_done      <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_dbz   <= 1'b0;
            end
`else
            r_state <= S_RUN;
            r_busy  <= 1'b1;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end

        // One restoring iteration per cycle; start is ignored here.
        S_RUN: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=8).
// Expected results come from plain integer division in a reference model;
// expected latency and flags follow the DIV_ZERO_CHECK_EN build macro.
module tb_seq_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: unsigned division with the zero-divisor convention.
  function automatic logic [31:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return (1 << W) - 1;
    return 32'(a) / 32'(b);
  endfunction

  function automatic logic [31:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return 32'(a);
    return 32'(a) % 32'(b);
  endfunction

  function automatic bit zero_fast(input logic [W-1:0] b);
`ifdef DIV_ZERO_CHECK_EN
    return (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Issue one division. Must be called at a negedge (which may be the negedge
  // of a DONE cycle, for back-to-back). Returns at the negedge where done was
  // seen. poke>0 re-asserts start with junk operands in that cycle of the run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke, input string name);
    int cycles;
    int busy_cnt;
    bit seen;
    logic [31:0] ident;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    cycles   = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1'b1;
      end else if (cycles == poke) begin
        bus.start    = 1'b1;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({name, "/done_seen"}, 32'(seen), 32'd1);
    check({name, "/latency"}, 32'(cycles), zero_fast(b) ? 32'd1 : 32'(W + 1));
    check({name, "/busy_cycles"}, 32'(busy_cnt), zero_fast(b) ? 32'd0 : 32'(W));
    check({name, "/quotient"}, 32'(bus.quotient), ref_q(a, b));
    check({name, "/remainder"}, 32'(bus.remainder), ref_r(a, b));
    check({name, "/div_by_zero"}, 32'(bus.div_by_zero), 32'(zero_fast(b)));
    if (b != 0) begin
      ident = 32'(bus.quotient) * 32'(b) + 32'(bus.remainder);
      check({name, "/identity"}, ident, 32'(a));
      check({name, "/rem_lt_div"}, 32'(bus.remainder < b), 32'd1);
    end
    $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d",
             name, a, b, bus.quotient, bus.remainder, bus.div_by_zero, cycles);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int kind;
    int gap;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/quotient", 32'(bus.quotient), 32'd0);
    check("reset/remainder", 32'(bus.remainder), 32'd0);
    check("reset/div_by_zero", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic operation, then done must be a single-cycle pulse with held results.
    run_op(8'd100, 8'd7, 0, "100/7");
    @(negedge clk);
    check("100/7/done_pulse_end", 32'(bus.done), 32'd0);
    check("100/7/q_held", 32'(bus.quotient), 32'd14);
    check("100/7/r_held", 32'(bus.remainder), 32'd2);

    // Back-to-back: second start issued in the DONE cycle of the first.
    @(negedge clk);
    run_op(8'd255, 8'd1, 0, "255/1");
    run_op(8'd5, 8'd9, 0, "5/9_b2b");

    // Start pulsed mid-run must be ignored.
    @(negedge clk);
    run_op(8'd200, 8'd13, 3, "200/13_poke");

    // Reset four cycles into a run aborts it.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd77;
    bus.divisor  = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort/busy", 32'(bus.busy), 32'd0);
    check("abort/done", 32'(bus.done), 32'd0);
    check("abort/quotient", 32'(bus.quotient), 32'd0);
    check("abort/remainder", 32'(bus.remainder), 32'd0);
    rst = 1'b0;
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    check("abort/no_done", 32'(seen_done), 32'd0);
    check("abort/idle_busy", 32'(bus.busy), 32'd0);
    run_op(8'd77, 8'd3, 0, "77/3");

    // Zero divisor, then a normal op that clears any flag.
    @(negedge clk);
    run_op(8'd37, 8'd0, 0, "37/0");
    @(negedge clk);
    check("37/0/flag_held", 32'(bus.div_by_zero), 32'(zero_fast(8'd0)));
    run_op(8'd10, 8'd3, 0, "10/3");

    // Randomised sweep with corner-case operand classes and random gaps.
    for (int i = 0; i < 1000; i++) begin
      kind = $urandom_range(0, 5);
      a = W'($urandom);
      b = W'($urandom);
      case (kind)
        0: a = '0;
        1: a = b;
        2: b = 8'd255;
        3: b = '0;
        default: ;
      endcase
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_op(a, b, 0, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
